// File: rtl/amber48_uart_rx.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO and sticky frame/overrun flags.
// Latency: byte visible on data_o/valid_o one cycle after the stop-bit sample (E+2226 from first low sample).
// Backpressure: pop on valid_o && ready_i; a byte arriving into a full FIFO with no pop is dropped and flags overrun.
module amber48_uart_rx #(
    parameter int CLOCK_FREQ_HZ = 27_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk_27mhz_i,
    input  logic       rst_sync_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       clr_err_i
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int PTR_W        = AW + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic rx_s;
    logic push;
    logic ferr_set;
    logic empty;
    logic full;
    logic pop;
    logic accept;
    logic ovr_set;

    assign rx_s = sync2_q;

    always_comb begin
        sync1_d  = rx_i;
        sync2_d  = sync1_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    // A start bit that has gone high again by mid-bit is line noise.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        idx_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = '0;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                // Wait out a held-low line so it cannot re-trigger as a stream of frames.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
        pop     = !empty && ready_i;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        accept  = push && (!full || pop);
        ovr_set = push && full && !pop;

        mem_d = mem_q;
        if (accept) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(accept);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        frame_err_d = frame_err_q;
        if (ferr_set) begin
            frame_err_d = 1'b1;
        end else if (clr_err_i) begin
            frame_err_d = 1'b0;
        end
        overrun_d = overrun_q;
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (clr_err_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_27mhz_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign valid_o     = !empty;
    assign data_o      = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_amber48_uart_rx.sv
// Bench for amber48_uart_rx: directed scenarios plus random frames against a queue-based receive model.
module tb_amber48_uart_rx;

    localparam int CPB   = 234;
    localparam int DEPTH = 4;

    logic       clk_27mhz_i = 1'b0;
    logic       rst_sync_n  = 1'b0;
    logic       rx_i        = 1'b1;
    logic       ready_i     = 1'b0;
    logic       clr_err_i   = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;

    amber48_uart_rx dut (
        .clk_27mhz_i (clk_27mhz_i),
        .rst_sync_n  (rst_sync_n),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .clr_err_i   (clr_err_i)
    );

    always #5 clk_27mhz_i = ~clk_27mhz_i;

    int cyc = 0;
    always @(posedge clk_27mhz_i) cyc <= cyc + 1;

    int         n_vec  = 0;
    int         n_err  = 0;
    int         e_edge = 0;
    logic [7:0] exp_q[$];
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: what the receiver should hold after a whole frame.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)                  m_ferr = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                           m_ovr = 1'b1;
    endtask

    task automatic start_bit();
        @(posedge clk_27mhz_i);
        #1 rx_i = 1'b0;
        e_edge = cyc + 1;
        repeat (CPB) @(posedge clk_27mhz_i);
    endtask

    task automatic send_rest(input logic [7:0] b, input bit stop_ok, input int extra_low);
        for (int i = 0; i < 8; i++) begin
            #1 rx_i = b[i];
            repeat (CPB) @(posedge clk_27mhz_i);
        end
        #1 rx_i = stop_ok;
        repeat (CPB) @(posedge clk_27mhz_i);
        if (!stop_ok) begin
            repeat (extra_low) @(posedge clk_27mhz_i);
            #1 rx_i = 1'b1;
            repeat (4) @(posedge clk_27mhz_i);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low);
        start_bit();
        send_rest(b, stop_ok, extra_low);
        model_frame(b, stop_ok);
    endtask

    // Returns at the negedge following edge e_edge+offset.
    task automatic wait_edge(input int offset);
        int guard = 0;
        do begin
            @(negedge clk_27mhz_i);
            guard++;
        end while ((e_edge == 0 || cyc < e_edge + offset) && guard < 5000);
        check_eq("wait_bound", (guard < 5000), 1);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk_27mhz_i);
        check_eq({tag, "_valid"}, valid_o, (exp_q.size() != 0));
        check_eq({tag, "_data"}, data_o, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
        check_eq({tag, "_ferr"}, frame_err_o, m_ferr);
        check_eq({tag, "_ovr"}, overrun_o, m_ovr);
    endtask

    task automatic pop_one(input string tag);
        @(negedge clk_27mhz_i);
        check_eq({tag, "_pop_valid"}, valid_o, 1);
        check_eq({tag, "_pop_data"}, data_o, exp_q[0]);
        ready_i = 1'b1;
        @(posedge clk_27mhz_i);
        #1 ready_i = 1'b0;
        void'(exp_q.pop_front());
    endtask

    task automatic clear_flags();
        @(negedge clk_27mhz_i);
        clr_err_i = 1'b1;
        @(posedge clk_27mhz_i);
        #1 clr_err_i = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    initial begin
        repeat (150_000) @(posedge clk_27mhz_i);
        $display("FAIL watchdog: cycle %0d reached, bench did not complete", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] fill [4];
        bit         ok;
        int         npop;

        // Reset state
        repeat (5) @(posedge clk_27mhz_i);
        check_state("reset");
        @(negedge clk_27mhz_i) rst_sync_n = 1'b1;
        repeat (5) @(posedge clk_27mhz_i);

        // 0x55 with exact latency to valid_o
        e_edge = 0;
        fork
            begin
                start_bit();
                send_rest(8'h55, 1'b1, 0);
            end
            begin
                wait_edge(2224);
                check_eq("lat_before_valid", valid_o, 0);
                @(negedge clk_27mhz_i);
                check_eq("lat_valid", valid_o, 1);
                check_eq("lat_data", data_o, 8'h55);
                check_eq("lat_ferr", frame_err_o, 0);
                check_eq("lat_ovr", overrun_o, 0);
            end
        join
        exp_q.push_back(8'h55);
        pop_one("x55");
        check_state("x55_empty");

        // Short glitch is rejected, next frame still received
        @(posedge clk_27mhz_i);
        #1 rx_i = 1'b0;
        repeat (50) @(posedge clk_27mhz_i);
        #1 rx_i = 1'b1;
        repeat (300) @(posedge clk_27mhz_i);
        check_state("glitch");
        send_frame(8'hC3, 1'b1, 0);
        check_state("xC3");
        pop_one("xC3");

        // Framing error with line held low, then clear and recover
        send_frame(8'h7E, 1'b0, 1000 - CPB);
        check_state("ferr");
        clear_flags();
        check_state("ferr_clr");
        send_frame(8'h01, 1'b1, 0);
        check_state("x01");
        pop_one("x01");

        // Overrun: five bytes into a four-deep FIFO, then continuous drain
        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1, 0);
        check_state("ovr");
        @(negedge clk_27mhz_i) ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk_27mhz_i);
            check_eq("drain_valid", valid_o, (i < 4));
            check_eq("drain_data", data_o, (i < 4) ? 8'h10 + 8'(i) : 8'h00);
        end
        ready_i = 1'b0;
        exp_q.delete();
        clear_flags();
        check_state("drain_done");

        // Full FIFO with a pop exactly at the push of a fifth byte
        for (int i = 0; i < 4; i++) begin
            fill[i] = 8'($urandom);
            send_frame(fill[i], 1'b1, 0);
        end
        e_edge = 0;
        fork
            begin
                start_bit();
                send_rest(8'h99, 1'b1, 0);
            end
            begin
                wait_edge(2224);
                ready_i = 1'b1;
                @(posedge clk_27mhz_i);
                #1 ready_i = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(8'h99);
        check_state("simul");
        check_eq("simul_head", data_o, fill[1]);
        for (int i = 0; i < 4; i++) pop_one("simul");
        check_state("simul_empty");

        // Reset during data bit 4; FIFO holds a byte beforehand
        send_frame(8'hA7, 1'b1, 0);
        b = 8'h3C;
        start_bit();
        for (int i = 0; i < 4; i++) begin
            #1 rx_i = b[i];
            repeat (CPB) @(posedge clk_27mhz_i);
        end
        #1 rx_i = b[4];
        repeat (100) @(posedge clk_27mhz_i);
        #1 rst_sync_n = 1'b0;
        rx_i = 1'b1;
        exp_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_state("in_reset");
        repeat (10) @(posedge clk_27mhz_i);
        #1 rst_sync_n = 1'b1;
        repeat (20) @(posedge clk_27mhz_i);
        check_state("post_reset");
        send_frame(8'hF0, 1'b1, 0);
        check_state("xF0");
        pop_one("xF0");

        // Random frames, random stop validity, random draining and clears
        for (int n = 0; n < 12; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok, $urandom_range(0, 300));
            check_state("rnd_frame");
            npop = $urandom_range(0, exp_q.size());
            for (int k = 0; k < npop; k++) pop_one("rnd");
            if ($urandom_range(0, 2) == 0) clear_flags();
            check_state("rnd_after");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/amber48_uart_rx.md
# amber48_uart_rx

UART receiver for the amber48 FPGA top level. It samples the serial line `rx_i`, deframes 8N1 characters and buffers them in a small first-word-fall-through FIFO. `amber48_dmem` drains the FIFO through a valid/ready pop interface for MMIO reads. It is the receive-side counterpart of `amber48_uart_tx` and shares the same clock and reset and the same baud parameters.

## Interface
Parameters:
- `CLOCK_FREQ_HZ`, default 27_000_000: input clock frequency.
- `BAUD_RATE`, default 115_200: line rate. `CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE`, integer-truncated, which is 234. `HALF_BIT = CLKS_PER_BIT / 2`, which is 117.
- `FIFO_DEPTH`, default 4: receive buffer entries. Must be a power of 2 and ≥2.

Ports:
- `clk_27mhz_i`  in  1  system clock.
- `rst_sync_n`  in  1  reset, asynchronous, active-low.
- `rx_i`  in  1  serial line. Asynchronous to the clock. Idle high.
- `data_o`  out  8  FIFO head byte. Forced to 8'h00 when `valid_o`=0.
- `valid_o`  out  1  FIFO not empty.
- `ready_i`  in  1  consumer pop. A pop occurs on `valid_o && ready_i`.
- `frame_err_o`  out  1  sticky: stop bit was sampled low.
- `overrun_o`  out  1  sticky: a byte arrived while the FIFO was full.
- `clr_err_i`  in  1  single-cycle clear of both sticky flags.

## Operation
- **Synchronizer.** `rx_i` passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized value `rx_s`.
- **FSM states.** IDLE, START, DATA, STOP, BREAK. A bit counter `cnt` counts 0..CLKS_PER_BIT-1. A bit index `idx` counts 0..7.
  - IDLE: `rx_s`=0 → START, with `cnt`=0.
  - START: when `cnt`=HALF_BIT-1, sample `rx_s`. If it is 1, treat it as a glitch and return to IDLE with no flag. If it is 0, go to DATA with `cnt`=0 and `idx`=0.
  - DATA: when `cnt`=CLKS_PER_BIT-1, sample `rx_s` into `shift[idx]`, LSB first, and reset `cnt`. After `idx`=7 go to STOP.
  - STOP: when `cnt`=CLKS_PER_BIT-1, sample `rx_s`.
    - If it is 1, push the shift register and go to IDLE.
    - If it is 0, set `frame_err_o`, discard the byte and go to BREAK.
  - BREAK: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- **FIFO.**
  - Read/write pointers with an extra wrap bit. Full when the pointers differ only in the wrap bit; empty when they are equal.
  - Push and pop in the same cycle are both performed. When the FIFO is full, the simultaneous pop frees the slot, so the push is accepted and `overrun_o` is not set.
  - A push while full without a pop drops the new byte, keeps the old contents and sets `overrun_o`.
  - A pop while empty is ignored.
- **Sticky flags.** `clr_err_i` clears both flags. If a set event and `clr_err_i` occur in the same cycle, set wins.
- **Arithmetic.** `cnt` is `$clog2(CLKS_PER_BIT)` bits wide. Pointers are `$clog2(FIFO_DEPTH)+1` bits and wrap naturally.

## Timing
- **Reset values.** `data_o`=8'h00, `valid_o`=0, `frame_err_o`=0, `overrun_o`=0. FSM in IDLE, FIFO empty, synchronizer flops at 1.
- **Reset mid-frame.** Reset abandons the frame. After release the FSM is in IDLE. If the line is still low, that is detected as a new start.
- **Frame latency.** Let E be the first clock edge at which `rx_i` is sampled low.
  - `rx_s` goes low at E+2.
  - Start-bit sample at E+119.
  - Data bit i sampled at E+119+234·(i+1).
  - Stop sample at E+2225.
  - `valid_o`=1 and `data_o` valid from E+2226.
- **Flag latency.** `frame_err_o` and `overrun_o` assert in the cycle after the stop sample (E+2226).
- **Pop timing.** A pop in cycle N updates `data_o`/`valid_o` at N+1. The FIFO is first-word-fall-through with no read latency.
- **Back-to-back frames.** A start bit immediately following a valid stop bit is accepted. The FSM is in IDLE by the stop-sample cycle + 1.

## Test plan
- Drive 8N1 byte 0x55 at 234 clk/bit, `ready_i`=0 → `valid_o` rises at E+2226 with `data_o`=8'hA5? No: `data_o`=8'h55. Both flags stay 0.
- Drive a 50-cycle low glitch on idle `rx_i` → FSM returns to IDLE and `valid_o` stays 0. A following 0xC3 frame is received correctly.
- Send 0x7E with the stop bit forced low, holding the line low for 1000 cycles → `frame_err_o`=1, no byte pushed, FSM waits in BREAK. Then pulse `clr_err_i` and send 0x01 → `frame_err_o`=0 and `data_o`=8'h01.
- Send 0x10..0x14 (5 bytes) with `ready_i`=0 → FIFO holds 0x10..0x13 and `overrun_o`=1. Then drain with `ready_i`=1 → exactly 4 pops in order, after which `valid_o`=0.
- With the FIFO full, assert `ready_i` for one cycle exactly at the stop-sample push of a 5th byte 0x99 → `overrun_o` stays 0. Read order is 2nd, 3rd, 4th, then 0x99.
- Assert reset at data bit 4 of a frame, release, then send 0xF0 → no partial byte appears and 0xF0 is received. All outputs read 0 during reset.
